// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor: fetch PC generator with direct-mapped BTB and 2-bit direction counters
//   i_Clk, i_Rst (async, active-high)  clock and reset
//   i_Stall                             hold the fetch PC
//   i_Ex_*                              resolved branch/jump from execute (valid, pc, new pc, prediction ok, taken)
//   o_PC / o_PPC / o_Pred_Taken         fetch PC, predicted next PC, prediction came from the BTB
//   o_Flush                             mispredict redirect this cycle
module fetch_pc_predictor #(
  parameter int WIDTH = 32,
  parameter int ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Stall,
  input  logic             i_Ex_Valid,
  input  logic [WIDTH-1:0] i_Ex_PC,
  input  logic [WIDTH-1:0] i_Ex_New_PC,
  input  logic             i_Ex_PPC_Eq,
  input  logic             i_Ex_Taken,
  output logic [WIDTH-1:0] o_PC,
  output logic [WIDTH-1:0] o_PPC,
  output logic             o_Pred_Taken,
  output logic             o_Flush
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW = WIDTH - IDX - 2;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TW-1:0]    tag_q [ENTRIES];
  logic [TW-1:0]    tag_d [ENTRIES];
  logic [WIDTH-1:0] tgt_q [ENTRIES];
  logic [WIDTH-1:0] tgt_d [ENTRIES];
  logic [1:0]       ctr_q [ENTRIES];
  logic [1:0]       ctr_d [ENTRIES];
  logic [IDX-1:0]   lk_idx, ex_idx;
  logic [TW-1:0]    lk_tag, ex_tag;
  logic             lk_hit, ex_hit, mispredict;
  logic             unused_lsb;
  assign unused_lsb = ^i_Ex_PC[1:0];
  assign o_PC = pc_q;
  always_comb begin
    lk_idx = pc_q[IDX+1:2];
    lk_tag = pc_q[WIDTH-1:IDX+2];
    lk_hit = valid_q[lk_idx] && tag_q[lk_idx] == lk_tag;
    o_Pred_Taken = lk_hit && ctr_q[lk_idx][1];
    o_PPC = o_Pred_Taken ? tgt_q[lk_idx] : pc_q + WIDTH'(4);
    mispredict = i_Ex_Valid && !i_Ex_PPC_Eq;
    // reset dominates the redirect, so the flush is suppressed while it is held
    o_Flush = mispredict && !i_Rst;
    pc_d = mispredict ? i_Ex_New_PC : i_Stall ? pc_q : o_PPC;
  end
  // training reads pre-write contents; the fetch lookup above never sees this cycle's write
  always_comb begin
    ex_idx = i_Ex_PC[IDX+1:2];
    ex_tag = i_Ex_PC[WIDTH-1:IDX+2];
    ex_hit = valid_q[ex_idx] && tag_q[ex_idx] == ex_tag;
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (i_Ex_Valid && i_Ex_Taken) begin
      valid_d[ex_idx] = 1'b1;
      tag_d[ex_idx] = ex_tag;
      tgt_d[ex_idx] = i_Ex_New_PC;
      ctr_d[ex_idx] = !ex_hit ? 2'b10 : ctr_q[ex_idx] == 2'b11 ? 2'b11 : ctr_q[ex_idx] + 2'd1;
    end else if (i_Ex_Valid && ex_hit) begin
      ctr_d[ex_idx] = ctr_q[ex_idx] == 2'b00 ? 2'b00 : ctr_q[ex_idx] - 2'd1;
    end
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pc_q <= RESET_PC;
      for (int e = 0; e < ENTRIES; e++) begin
        valid_q[e] <= 1'b0;
        tag_q[e] <= '0;
        tgt_q[e] <= '0;
        ctr_q[e] <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_predictor.sv
// tb_fetch_pc_predictor: scoreboard bench with a behavioural BTB model for fetch_pc_predictor
module tb_fetch_pc_predictor;
  localparam int N = 16;
  localparam int SH = $clog2(N) + 2;
  logic i_Clk = 1'b0;
  logic i_Rst, i_Stall, i_Ex_Valid, i_Ex_PPC_Eq, i_Ex_Taken;
  logic [31:0] i_Ex_PC, i_Ex_New_PC, o_PC, o_PPC;
  logic o_Pred_Taken, o_Flush;
  always #5 i_Clk = ~i_Clk;
  fetch_pc_predictor #(.WIDTH(32), .ENTRIES(N), .RESET_PC(32'h0)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Stall(i_Stall), .i_Ex_Valid(i_Ex_Valid),
    .i_Ex_PC(i_Ex_PC), .i_Ex_New_PC(i_Ex_New_PC), .i_Ex_PPC_Eq(i_Ex_PPC_Eq),
    .i_Ex_Taken(i_Ex_Taken), .o_PC(o_PC), .o_PPC(o_PPC), .o_Pred_Taken(o_Pred_Taken),
    .o_Flush(o_Flush)
  );
  typedef struct {logic [31:0] pc; logic [31:0] ppc; logic pt; logic fl;} exp_t;
  typedef struct {bit v; logic [31:0] owner; logic [31:0] tgt; int ctr;} ent_t;
  exp_t sb[$];
  ent_t btb[N];
  logic [31:0] mpc;
  int checks = 0;
  int errors = 0;
  function automatic int ix(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction
  function automatic bit hit_of(input logic [31:0] a);
    return btb[ix(a)].v && (btb[ix(a)].owner >> SH) == (a >> SH);
  endfunction
  task automatic mreset();
    mpc = 32'h0;
    foreach (btb[k]) btb[k] = '{1'b0, 32'h0, 32'h0, 1};
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic set_in(input bit st, input bit v, input logic [31:0] pc, input logic [31:0] npc,
                        input bit eq, input bit tk);
    i_Stall = st;
    i_Ex_Valid = v;
    i_Ex_PC = pc;
    i_Ex_New_PC = npc;
    i_Ex_PPC_Eq = eq;
    i_Ex_Taken = tk;
  endtask
  task automatic tick();
    exp_t e;
    int k;
    bit h;
    if (i_Rst) begin
      mreset();
      e = '{32'h0, 32'h4, 1'b0, 1'b0};
      sb.push_back(e);
    end else begin
      k = ix(mpc);
      e.pc = mpc;
      e.pt = hit_of(mpc) && btb[k].ctr >= 2;
      e.ppc = e.pt ? btb[k].tgt : mpc + 32'd4;
      e.fl = i_Ex_Valid && !i_Ex_PPC_Eq;
      sb.push_back(e);
      mpc = e.fl ? i_Ex_New_PC : i_Stall ? mpc : e.ppc;
      if (i_Ex_Valid) begin
        k = ix(i_Ex_PC);
        h = hit_of(i_Ex_PC);
        if (i_Ex_Taken) begin
          btb[k].ctr = !h ? 2 : btb[k].ctr < 3 ? btb[k].ctr + 1 : 3;
          btb[k].v = 1'b1;
          btb[k].owner = i_Ex_PC;
          btb[k].tgt = i_Ex_New_PC;
        end else if (h) begin
          btb[k].ctr = btb[k].ctr > 0 ? btb[k].ctr - 1 : 0;
        end
      end
    end
    @(posedge i_Clk);
    #1;
  endtask
  always @(negedge i_Clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_pc", o_PC, e.pc);
      chk("sb_ppc", o_PPC, e.ppc);
      chk("sb_pred_taken", 32'(o_Pred_Taken), 32'(e.pt));
      chk("sb_flush", 32'(o_Flush), 32'(e.fl));
    end
  end
  initial begin
    i_Rst = 1'b1;
    set_in(0, 0, 32'h0, 32'h0, 1, 0);
    mreset();
    @(posedge i_Clk);
    #1;
    tick();
    i_Rst = 1'b0;
    repeat (4) tick();
    chk("free_run_pc", o_PC, 32'h10);
    repeat (3) begin
      set_in(1, 0, 32'h0, 32'h0, 1, 0);
      tick();
    end
    chk("stall_hold", o_PC, 32'h10);
    set_in(0, 0, 32'h0, 32'h0, 1, 0);
    tick();
    chk("stall_release", o_PC, 32'h14);
    set_in(1, 1, 32'h20, 32'h100, 0, 1);
    #1 chk("flush_on_mispredict", 32'(o_Flush), 32'd1);
    tick();
    chk("redirect_pc", o_PC, 32'h100);
    set_in(0, 1, 32'h300, 32'h20, 0, 0);
    tick();
    set_in(1, 0, 32'h0, 32'h0, 1, 0);
    #1 chk("alloc_ppc", o_PPC, 32'h100);
    chk("alloc_pred", 32'(o_Pred_Taken), 32'd1);
    repeat (3) begin
      set_in(1, 1, 32'h20, 32'h100, 1, 1);
      tick();
    end
    repeat (2) begin
      set_in(1, 1, 32'h20, 32'h24, 1, 0);
      tick();
    end
    chk("weak_nt_ppc", o_PPC, 32'h24);
    repeat (3) begin
      set_in(1, 1, 32'h20, 32'h24, 1, 0);
      tick();
    end
    set_in(1, 1, 32'h20, 32'h100, 1, 1);
    tick();
    chk("sat_low_then_taken_ppc", o_PPC, 32'h24);
    tick();
    set_in(1, 1, 32'h20, 32'h180, 1, 1);
    #1 chk("same_cycle_old_target", o_PPC, 32'h100);
    tick();
    chk("same_cycle_new_target", o_PPC, 32'h180);
    set_in(1, 1, 32'h60, 32'h200, 1, 1);
    tick();
    chk("alias_evicted_ppc", o_PPC, 32'h24);
    set_in(0, 1, 32'h500, 32'h60, 0, 0);
    tick();
    set_in(1, 0, 32'h0, 32'h0, 1, 0);
    #1 chk("alias_new_owner_ppc", o_PPC, 32'h200);
    set_in(0, 1, 32'h500, 32'hFFFF_FFFC, 0, 0);
    tick();
    set_in(1, 0, 32'h0, 32'h0, 1, 0);
    #1 chk("wrap_ppc", o_PPC, 32'h0);
    tick();
    set_in(0, 1, 32'h40, 32'h400, 0, 1);
    i_Rst = 1'b1;
    #1 chk("reset_mid_pc", o_PC, 32'h0);
    chk("reset_mid_flush", 32'(o_Flush), 32'd0);
    tick();
    i_Rst = 1'b0;
    set_in(0, 1, 32'h500, 32'h60, 0, 0);
    tick();
    set_in(1, 0, 32'h0, 32'h0, 1, 0);
    #1 chk("reset_cleared_btb", o_PPC, 32'h64);
    chk("reset_cleared_pred", 32'(o_Pred_Taken), 32'd0);
    repeat (400) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             {24'h0, 6'($urandom_range(0, 63)), 2'b00}, {24'h0, 6'($urandom_range(0, 63)), 2'b00},
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      tick();
    end
    set_in(0, 0, 32'h0, 32'h0, 1, 0);
    @(negedge i_Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
